// File: rtl/c1541_sd_arbiter.sv
// Round-robin arbiter sharing one SD block port among NDR C1541 drives.
// One transfer in flight at a time; ack and write data follow the granted drive only.
`timescale 1ns/1ps
module c1541_sd_arbiter #(
    parameter int unsigned NDR = 2,
    parameter int unsigned TMO = 4095
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [32*NDR-1:0] drv_lba,
    input  logic [6*NDR-1:0]  drv_blk_cnt,
    input  logic [NDR-1:0]    drv_rd,
    input  logic [NDR-1:0]    drv_wr,
    output logic [NDR-1:0]    drv_ack,
    input  logic [8*NDR-1:0]  drv_buff_din,
    output logic [31:0]       sd_lba,
    output logic [5:0]        sd_blk_cnt,
    output logic              sd_rd,
    output logic              sd_wr,
    input  logic              sd_ack,
    output logic [7:0]        sd_buff_din,
    output logic [1:0]        gnt,
    output logic              busy,
    output logic              tmo_err
);

    localparam int unsigned CntW = (TMO > 1) ? $clog2(TMO) : 1;
    localparam logic [CntW-1:0] TmoLast = CntW'((TMO > 0) ? TMO - 1 : 0);

    typedef enum logic [1:0] {StIdle, StIssue, StXfer, StDone} state_e;

    state_e            state_q, state_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        last_q, last_d;
    logic [31:0]       lba_q, lba_d;
    logic [5:0]        blk_q, blk_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [NDR-1:0]    ack_q, ack_d;
    logic              tmo_q, tmo_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic [NDR-1:0]    req;
    logic              sel_valid;
    logic [1:0]        sel_idx;
    logic [31:0]       cand;
    logic [31:0]       sel_lba;
    logic [5:0]        sel_blk;
    logic              sel_rd;
    logic              gnt_req;
    logic [7:0]        gnt_din;

    assign req = drv_rd | drv_wr;

    // Scan from last+NDR down to last+1 so the nearest requester after last wins.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = NDR; k >= 1; k--) begin
            cand = (32'(last_q) + 32'(k)) % NDR;
            for (int i = 0; i < NDR; i++) begin
                if (cand == 32'(i) && req[i]) begin
                    sel_valid = 1'b1;
                    sel_idx   = 2'(i);
                end
            end
        end
    end

    always_comb begin
        sel_lba = '0;
        sel_blk = '0;
        sel_rd  = 1'b0;
        gnt_req = 1'b0;
        gnt_din = '0;
        for (int i = 0; i < NDR; i++) begin
            if (sel_idx == 2'(i)) begin
                sel_lba = drv_lba[32*i +: 32];
                sel_blk = drv_blk_cnt[6*i +: 6];
                sel_rd  = drv_rd[i];
            end
            if (gnt_q == 2'(i)) begin
                gnt_req = req[i];
                gnt_din = drv_buff_din[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        lba_d   = lba_q;
        blk_d   = blk_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        ack_d   = ack_q;
        tmo_d   = 1'b0;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                // A lingering host ack must clear before the port is handed out again.
                if (!sd_ack && sel_valid) begin
                    gnt_d   = sel_idx;
                    lba_d   = sel_lba;
                    blk_d   = sel_blk;
                    rd_d    = sel_rd;
                    wr_d    = ~sel_rd;
                    cnt_d   = '0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (sd_ack) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    ack_d   = NDR'(1) << gnt_q;
                    state_d = StXfer;
                end else if (!gnt_req) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = StIdle;
                end else if (TMO != 0 && cnt_q == TmoLast) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    tmo_d   = 1'b1;
                    last_d  = gnt_q;
                    state_d = StIdle;
                end else if (TMO != 0) begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StXfer: begin
                if (!sd_ack) begin
                    ack_d   = '0;
                    last_d  = gnt_q;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            last_q  <= 2'(NDR - 1);
            lba_q   <= '0;
            blk_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            ack_q   <= '0;
            tmo_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            lba_q   <= lba_d;
            blk_q   <= blk_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            ack_q   <= ack_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
        end
    end

    assign drv_ack     = ack_q;
    assign sd_lba      = lba_q;
    assign sd_blk_cnt  = blk_q;
    assign sd_rd       = rd_q;
    assign sd_wr       = wr_q;
    assign sd_buff_din = (state_q == StIdle) ? 8'h00 : gnt_din;
    assign gnt         = gnt_q;
    assign busy        = (state_q != StIdle);
    assign tmo_err     = tmo_q;

endmodule

// File: tb/tb_c1541_sd_arbiter.sv
// Bench for c1541_sd_arbiter: directed vector table, corner sequences, and random
// stimulus checked against a transaction-level reference model.
`timescale 1ns/1ps
module tb_c1541_sd_arbiter;

    localparam int unsigned NDR = 2;
    localparam int unsigned TMO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] drv_lba;
    logic [11:0] drv_blk_cnt;
    logic [1:0]  drv_rd, drv_wr, drv_ack;
    logic [15:0] drv_buff_din;
    logic [31:0] sd_lba;
    logic [5:0]  sd_blk_cnt;
    logic        sd_rd, sd_wr, sd_ack, busy, tmo_err;
    logic [7:0]  sd_buff_din;
    logic [1:0]  gnt;

    always #5 clk = ~clk;

    c1541_sd_arbiter #(.NDR(NDR), .TMO(TMO)) dut (
        .clk(clk), .reset(reset),
        .drv_lba(drv_lba), .drv_blk_cnt(drv_blk_cnt),
        .drv_rd(drv_rd), .drv_wr(drv_wr), .drv_ack(drv_ack),
        .drv_buff_din(drv_buff_din),
        .sd_lba(sd_lba), .sd_blk_cnt(sd_blk_cnt),
        .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
        .sd_buff_din(sd_buff_din), .gnt(gnt), .busy(busy), .tmo_err(tmo_err)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [1:0]  rd, wr;
        logic        ack;
        logic        e_rd, e_wr;
        logic [1:0]  e_ack, e_gnt;
        logic        e_busy;
        logic [31:0] e_lba;
        logic [5:0]  e_blk;
        logic [7:0]  e_din;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] rd, input logic [1:0] wr, input logic ack,
                                input logic e_rd, input logic e_wr, input logic [1:0] e_ack,
                                input logic [1:0] e_gnt, input logic e_busy,
                                input logic [31:0] e_lba, input logic [5:0] e_blk,
                                input logic [7:0] e_din);
        vec_t v;
        v.rd = rd; v.wr = wr; v.ack = ack;
        v.e_rd = e_rd; v.e_wr = e_wr; v.e_ack = e_ack; v.e_gnt = e_gnt;
        v.e_busy = e_busy; v.e_lba = e_lba; v.e_blk = e_blk; v.e_din = e_din;
        return v;
    endfunction

    // Reference model: one in-flight transfer, described by its phase flags.
    bit          m_wait, m_move, m_settle;
    int          m_age, m_last;
    logic [1:0]  m_gnt, m_ack;
    logic        m_rd, m_wr, m_tmo;
    logic [31:0] m_lba;
    logic [5:0]  m_blk;

    function automatic void model_reset();
        m_wait = 0; m_move = 0; m_settle = 0; m_age = 0; m_last = NDR - 1;
        m_gnt = 0; m_ack = 0; m_rd = 0; m_wr = 0; m_tmo = 0; m_lba = 0; m_blk = 0;
    endfunction

    function automatic void model_edge();
        logic [1:0] req;
        req   = drv_rd | drv_wr;
        m_tmo = 0;
        if (m_settle) begin
            m_settle = 0;
        end else if (m_move) begin
            if (!sd_ack) begin
                m_move = 0; m_settle = 1; m_ack = 0; m_last = int'(m_gnt);
            end
        end else if (m_wait) begin
            if (sd_ack) begin
                m_wait = 0; m_move = 1; m_rd = 0; m_wr = 0;
                m_ack = 2'b01 << m_gnt;
            end else if (!req[m_gnt]) begin
                m_wait = 0; m_rd = 0; m_wr = 0;
            end else if (m_age == TMO - 1) begin
                m_wait = 0; m_rd = 0; m_wr = 0; m_tmo = 1; m_last = int'(m_gnt);
            end else begin
                m_age++;
            end
        end else if (!sd_ack) begin
            for (int k = 1; k <= NDR; k++) begin
                int i;
                i = (m_last + k) % NDR;
                if (!m_wait && req[i]) begin
                    m_wait = 1; m_age = 0; m_gnt = 2'(i);
                    m_lba = drv_lba[32*i +: 32];
                    m_blk = drv_blk_cnt[6*i +: 6];
                    m_rd = drv_rd[i]; m_wr = ~drv_rd[i];
                end
            end
        end
    endfunction

    function automatic logic [63:0] outs();
        return {10'b0, sd_rd, sd_wr, drv_ack, gnt, busy, tmo_err, sd_lba, sd_blk_cnt, sd_buff_din};
    endfunction

    vec_t       vecs[17];
    logic [1:0] got[4];
    int         n, hi;
    logic [7:0] e_din;
    bit         e_busy;

    initial begin
        vecs[0]  = mk(2'b01, 2'b00, 0, 1, 0, 2'b00, 0, 1, 32'h15, 6'd0, 8'h5A);
        vecs[1]  = mk(2'b01, 2'b00, 1, 0, 0, 2'b01, 0, 1, 32'h15, 6'd0, 8'h5A);
        vecs[2]  = mk(2'b01, 2'b00, 1, 0, 0, 2'b01, 0, 1, 32'h15, 6'd0, 8'h5A);
        vecs[3]  = mk(2'b01, 2'b00, 1, 0, 0, 2'b01, 0, 1, 32'h15, 6'd0, 8'h5A);
        vecs[4]  = mk(2'b01, 2'b00, 0, 0, 0, 2'b00, 0, 1, 32'h15, 6'd0, 8'h5A);
        vecs[5]  = mk(2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 0, 32'h15, 6'd0, 8'h00);
        vecs[6]  = mk(2'b10, 2'b10, 0, 1, 0, 2'b00, 1, 1, 32'h2A, 6'd3, 8'hA5);
        vecs[7]  = mk(2'b10, 2'b10, 1, 0, 0, 2'b10, 1, 1, 32'h2A, 6'd3, 8'hA5);
        vecs[8]  = mk(2'b10, 2'b10, 1, 0, 0, 2'b10, 1, 1, 32'h2A, 6'd3, 8'hA5);
        vecs[9]  = mk(2'b00, 2'b00, 0, 0, 0, 2'b00, 1, 1, 32'h2A, 6'd3, 8'hA5);
        vecs[10] = mk(2'b00, 2'b01, 0, 0, 0, 2'b00, 1, 0, 32'h2A, 6'd3, 8'h00);
        vecs[11] = mk(2'b00, 2'b01, 0, 0, 1, 2'b00, 0, 1, 32'h15, 6'd0, 8'h5A);
        vecs[12] = mk(2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 0, 32'h15, 6'd0, 8'h00);
        vecs[13] = mk(2'b00, 2'b01, 0, 0, 1, 2'b00, 0, 1, 32'h15, 6'd0, 8'h5A);
        vecs[14] = mk(2'b00, 2'b01, 1, 0, 0, 2'b01, 0, 1, 32'h15, 6'd0, 8'h5A);
        vecs[15] = mk(2'b00, 2'b01, 0, 0, 0, 2'b00, 0, 1, 32'h15, 6'd0, 8'h5A);
        vecs[16] = mk(2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 0, 32'h15, 6'd0, 8'h00);

        reset = 1'b1;
        drv_lba = {32'h2A, 32'h15};
        drv_blk_cnt = {6'd3, 6'd0};
        drv_rd = 0; drv_wr = 0; sd_ack = 0;
        drv_buff_din = 16'hA55A;
        #3;
        chk("reset_state", outs(), 64'h0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[r]) begin
            drv_rd = vecs[r].rd; drv_wr = vecs[r].wr; sd_ack = vecs[r].ack;
            step();
            chk($sformatf("vec%0d_ctl", r), {sd_rd, sd_wr, drv_ack, gnt, busy, tmo_err},
                {vecs[r].e_rd, vecs[r].e_wr, vecs[r].e_ack, vecs[r].e_gnt, vecs[r].e_busy, 1'b0});
            chk($sformatf("vec%0d_data", r), {sd_lba, sd_blk_cnt, sd_buff_din},
                {vecs[r].e_lba, vecs[r].e_blk, vecs[r].e_din});
        end

        // Both drives request continuously; last grant went to drive 0.
        drv_rd = 2'b11; sd_ack = 0; n = 0;
        for (int c = 0; c < 60 && n < 4; c++) begin
            step();
            if (sd_rd) begin
                got[n] = gnt; n++; sd_ack = 1;
            end else begin
                sd_ack = 0;
            end
        end
        chk("alt_count", 64'(n), 64'd4);
        for (int i = 0; i < 4; i++) chk($sformatf("alt_gnt%0d", i), 64'(got[i]), 64'(i % 2 == 0 ? 1 : 0));
        step();
        sd_ack = 0; drv_rd = 0;
        step(); step();
        chk("alt_idle", 64'(busy), 64'd0);

        // Timeout on drive 0 with drive 1 waiting behind it.
        drv_rd = 2'b01;
        step();
        chk("tmo_grant", {sd_rd, gnt}, {1'b1, 2'd0});
        drv_rd = 2'b11; hi = 1;
        for (int c = 0; c < 20; c++) begin
            step();
            if (!sd_rd) break;
            hi++;
        end
        chk("tmo_len", 64'(hi), 64'd8);
        chk("tmo_pulse", {tmo_err, busy}, 2'b10);
        step();
        chk("tmo_next", {tmo_err, sd_rd, gnt}, {1'b0, 1'b1, 2'd1});
        drv_rd = 2'b00;
        step(); step();
        chk("tmo_cancel", {busy, sd_rd}, 2'b00);

        // Stale ack blocks granting; then async reset in the middle of a transfer.
        drv_rd = 2'b01; sd_ack = 1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("stray_ack", {busy, sd_rd}, 2'b00);
        end
        sd_ack = 0;
        step();
        chk("stray_grant", {sd_rd, gnt}, {1'b1, 2'd0});
        sd_ack = 1;
        step(); step();
        chk("rst_xfer", 64'(drv_ack), 64'd1);
        #2 reset = 1'b1;
        #1 chk("rst_async", {drv_ack, sd_rd, busy}, 4'b0);
        drv_rd = 0; sd_ack = 0;
        @(negedge clk);
        reset = 1'b0;

        // Random traffic against the reference model.
        model_reset();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NDR; i++) begin
                if ($urandom_range(3) == 0) drv_rd[i] = ~drv_rd[i];
                if ($urandom_range(3) == 0) drv_wr[i] = ~drv_wr[i];
            end
            if ($urandom_range(2) == 0) sd_ack = ~sd_ack;
            drv_lba = {$urandom(), $urandom()};
            drv_blk_cnt = 12'($urandom());
            drv_buff_din = 16'($urandom());
            model_edge();
            step();
            e_busy = m_wait | m_move | m_settle;
            e_din = e_busy ? drv_buff_din[8*m_gnt +: 8] : 8'h00;
            chk($sformatf("rand%0d", c), outs(),
                {10'b0, m_rd, m_wr, m_ack, m_gnt, e_busy, m_tmo, m_lba, m_blk, e_din});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/c1541_sd_arbiter.md
Name: c1541_sd_arbiter

Overview:
- Shares one MiSTer-style SD block port (lba/blk_cnt/rd/wr/ack/buff_din) among up to 4 C1541 drive instances of the multi-drive wrapper.
- Round-robin arbitration, one outstanding transfer at a time; the granted drive's request is latched and forwarded.
- ack and write-data are routed back/forward for the granted drive only.
- Sits between the drive array and the single host SD interface, replacing per-drive SD ports.

Parameters:
- NDR, 2, number of drives; legal 1..4. Ports are flattened as index i occupying bits [W*i +: W].
- TMO, 4095, cycles to wait for sd_ack after issuing before aborting. 0 disables the timeout.

Ports:
- clk  in  1  core clock; everything is synchronous to it.
- reset  in  1  asynchronous, active-high.
- drv_lba  in  32*NDR  per-drive block address.
- drv_blk_cnt  in  6*NDR  per-drive block count minus 1.
- drv_rd  in  NDR  per-drive read request level.
- drv_wr  in  NDR  per-drive write request level.
- drv_ack  out  NDR  per-drive ack; high during the granted transfer only.
- drv_buff_din  in  8*NDR  per-drive write data.
- sd_lba  out  32  latched LBA of the granted request.
- sd_blk_cnt  out  6  latched block count.
- sd_rd  out  1  host read request.
- sd_wr  out  1  host write request.
- sd_ack  in  1  host ack.
- sd_buff_din  out  8  drv_buff_din of the granted drive; 0 when idle. Combinational mux on gnt.
- gnt  out  2  index of the granted or last-granted drive.
- busy  out  1  high in every state except IDLE.
- tmo_err  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset values: all outputs 0. State = IDLE. Round-robin pointer last = NDR-1, so drive 0 has first priority.
- A drive is requesting when drv_rd[i] | drv_wr[i]. If both are set, the request is treated as a read.
- IDLE:
  - Waits for sd_ack = 0. A stray or stale ack blocks granting.
  - Selects the first requesting i in order last+1, last+2, … (mod NDR).
  - On selection it registers gnt = i, sd_lba, sd_blk_cnt, and dir. The next cycle it asserts sd_rd or sd_wr, then goes to ISSUE. Latency from request to sd_rd/sd_wr high is exactly 1 clk.
- ISSUE:
  - sd_rd/sd_wr are held high and the timeout counter runs.
  - On sd_ack = 1: drop sd_rd/sd_wr, set drv_ack[gnt] = 1, go to XFER. drv_ack follows sd_ack with 1 clk delay.
  - If the granted drive's request drops before ack: cancel. Drop sd_rd/sd_wr, go to IDLE, pointer not updated.
  - If ack and request drop happen in the same cycle, ack wins.
  - If the counter reaches TMO: drop the request, pulse tmo_err, set last = gnt, go to IDLE.
- XFER:
  - drv_ack[gnt] = 1 while sd_ack = 1. Request changes are ignored.
  - On sd_ack = 0: drv_ack[gnt] = 0, set last = gnt, go to DONE.
- DONE: one idle cycle, with no new grant, so drives can see ack fall and drop their request. Then go to IDLE.
- Per-drive lba/blk_cnt changes after latching are ignored until the next grant.
- Non-granted drv_ack bits are always 0. At most one drv_ack bit is high at a time.
- Asynchronous reset at any point: outputs go to 0 immediately, with no completion handshake. The host is expected to be reset together with this block.
- NDR = 1: arbitration degenerates and gnt stays 0.

Test Plan:
- Reset, then drive 0 raises drv_rd with lba=0x15 and blk_cnt=0 -> next clk sd_rd=1, sd_lba=0x15, gnt=0. Ack high for 3 clks -> drv_ack[0] high for 3 clks starting 1 clk later, then DONE, then IDLE.
- NDR=2, drives 0 and 1 both request continuously -> grants alternate 0,1,0,1 over 4 transfers. No back-to-back grants to the same drive.
- Drive 1 sets drv_rd and drv_wr together -> sd_rd=1, sd_wr=0. While XFER, sd_buff_din equals drv_buff_din[15:8].
- Drive 0 drops drv_wr in ISSUE before ack -> sd_wr falls next clk, busy=0, tmo_err=0. Drive 0 re-requests -> granted again immediately.
- TMO=8 with no ack -> sd_rd high 8 clks, tmo_err single pulse, busy=0. A pending drive 1 request is granted next.
- sd_ack held high while in IDLE with drive 0 requesting -> no grant until sd_ack=0. Asserting reset mid-XFER -> drv_ack, sd_rd, and busy go to 0 without a clock edge.
